// File: rtl/vend_pkg.sv
// Shared types and constants for the vending scheduler: FSM states, price table and coin set.
// Coin helpers implement the greedy refund pick used while paying back credit.
package vend_pkg;

  localparam int CREDIT_W = 7;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    DEBIT,
    DISPENSE,
    REFUND_EJECT,
    REFUND_DEBIT,
    FAULT
  } state_t;

  // Index 0 is slot 0; values in 5-cent units.
  localparam logic [CREDIT_W-1:0] PRICE [4] = '{7'd25, 7'd30, 7'd15, 7'd40};

  // Indexed by coin_eject bit: [3]=$1, [2]=50c, [1]=10c, [0]=5c.
  localparam logic [CREDIT_W-1:0] COIN_VAL [3:0] = '{7'd20, 7'd10, 7'd2, 7'd1};

  // Largest coin not exceeding rem; later (larger) matches overwrite smaller ones.
  function automatic logic [3:0] coin_onehot(input logic [CREDIT_W-1:0] rem);
    logic [3:0] oh;
    oh = '0;
    for (int i = 0; i < 4; i++) begin
      if (COIN_VAL[i] <= rem) begin
        oh    = '0;
        oh[i] = 1'b1;
      end
    end
    return oh;
  endfunction

  function automatic logic [CREDIT_W-1:0] coin_value(input logic [3:0] oh);
    logic [CREDIT_W-1:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) v = v | COIN_VAL[i];
    end
    return v;
  endfunction

endpackage

// File: rtl/vend_scheduler_if.sv
// Keypad, accumulator, motor and hopper signals of the vending scheduler.
// master = scheduler side, slave = environment side.
interface vend_scheduler_if;
  import vend_pkg::*;

  logic [3:0]          sel;
  logic                cancel;
  logic [CREDIT_W-1:0] credit;
  logic                debit_ack;
  logic                motor_done;
  logic                eject_ready;
  logic                debit_valid;
  logic [CREDIT_W-1:0] debit_amt;
  logic [3:0]          motor_req;
  logic [3:0]          coin_eject;
  logic [3:0]          grant;
  logic [3:0]          reject;
  logic                busy;
  logic                fault;

  modport master (
    input  sel, cancel, credit, debit_ack, motor_done, eject_ready,
    output debit_valid, debit_amt, motor_req, coin_eject, grant, reject, busy, fault
  );

  modport slave (
    output sel, cancel, credit, debit_ack, motor_done, eject_ready,
    input  debit_valid, debit_amt, motor_req, coin_eject, grant, reject, busy, fault
  );

endinterface

// File: rtl/vend_rr_arb.sv
// 4-way combinational round-robin pick: first requester at or after ptr, wrapping.
// Zero latency; vld low when nothing requests.
module vend_rr_arb (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       vld,
  output logic [1:0] idx
);

  always_comb begin
    vld = |req;
    idx = ptr;
    // Walk from the farthest offset down so the nearest requester wins.
    for (int i = 3; i >= 0; i--) begin
      if (req[ptr + 2'(i)]) idx = ptr + 2'(i);
    end
  end

endmodule

// File: rtl/vend_scheduler.sv
// Vending scheduler: arbitrates purchases, debits, drives dispense motor, pays back refunds greedily.
// sel->grant in 2 cycles; debit/refund stall on debit_ack and eject_ready; motor timeout parks in FAULT.
module vend_scheduler
  import vend_pkg::*;
#(
  parameter int SLOTS     = 4,
  parameter int MOTOR_TMO = 255
) (
  input logic              CLK,
  input logic              RST,
  vend_scheduler_if.master bus
);

  localparam int SLOT_W = $clog2(SLOTS);
  localparam int TMR_W  = $clog2(MOTOR_TMO + 1);

  state_t              state, state_nxt;
  logic [SLOT_W-1:0]   rr_ptr, rr_nxt;
  logic [SLOT_W-1:0]   slot, slot_nxt;
  logic [CREDIT_W-1:0] rem, rem_nxt;
  logic [CREDIT_W-1:0] total, total_nxt;
  logic [TMR_W-1:0]    timer, timer_nxt;

  logic                arb_vld;
  logic [SLOT_W-1:0]   arb_idx;
  logic [3:0]          coin;

  logic                debit_valid;
  logic [CREDIT_W-1:0] debit_amt;
  logic [3:0]          motor_req, coin_eject, grant, reject;

  vend_rr_arb u_arb (
    .req (bus.sel),
    .ptr (rr_ptr),
    .vld (arb_vld),
    .idx (arb_idx)
  );

  assign coin = coin_onehot(rem);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      rr_ptr <= '0;
      slot   <= '0;
      rem    <= '0;
      total  <= '0;
      timer  <= '0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_nxt;
      slot   <= slot_nxt;
      rem    <= rem_nxt;
      total  <= total_nxt;
      timer  <= timer_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    rr_nxt      = rr_ptr;
    slot_nxt    = slot;
    rem_nxt     = rem;
    total_nxt   = total;
    timer_nxt   = timer;
    debit_valid = 1'b0;
    debit_amt   = '0;
    motor_req   = '0;
    coin_eject  = '0;
    grant       = '0;
    reject      = '0;

    case (state)
      IDLE: begin
        // cancel shadows sel even when there is nothing to refund
        if (bus.cancel) begin
          if (bus.credit != '0) begin
            state_nxt = REFUND_EJECT;
            rem_nxt   = bus.credit;
            total_nxt = bus.credit;
          end
        end else if (bus.sel != '0) begin
          state_nxt = ARB;
        end
      end
      ARB: begin
        state_nxt = IDLE;
        if (arb_vld) begin
          slot_nxt = arb_idx;
          if (PRICE[arb_idx] <= bus.credit) begin
            grant[arb_idx] = 1'b1;
            rr_nxt         = arb_idx + SLOT_W'(1);
            state_nxt      = DEBIT;
          end else begin
            reject[arb_idx] = 1'b1;
          end
        end
      end
      DEBIT: begin
        debit_valid = 1'b1;
        debit_amt   = PRICE[slot];
        if (bus.debit_ack) begin
          state_nxt = DISPENSE;
          timer_nxt = '0;
        end
      end
      DISPENSE: begin
        motor_req[slot] = 1'b1;
        if (bus.motor_done) state_nxt = IDLE;
        else if (timer == TMR_W'(MOTOR_TMO)) state_nxt = FAULT;
        else timer_nxt = timer + TMR_W'(1);
      end
      REFUND_EJECT: begin
        if (rem == '0) begin
          state_nxt = REFUND_DEBIT;
        end else if (bus.eject_ready) begin
          coin_eject = coin;
          rem_nxt    = rem - coin_value(coin);
        end
      end
      REFUND_DEBIT: begin
        debit_valid = 1'b1;
        debit_amt   = total;
        if (bus.debit_ack) state_nxt = IDLE;
      end
      default: ;
    endcase
  end

  assign bus.debit_valid = debit_valid;
  assign bus.debit_amt   = debit_amt;
  assign bus.motor_req   = motor_req;
  assign bus.coin_eject  = coin_eject;
  assign bus.grant       = grant;
  assign bus.reject      = reject;
  assign bus.busy        = (state != IDLE);
  assign bus.fault       = (state == FAULT);

endmodule

// File: tb/tb_vend_scheduler.sv
// Directed bench for vend_scheduler: purchases, reject, round-robin order, refund, timeout and reset.
module tb_vend_scheduler;
  import vend_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  vend_scheduler_if vif ();

  vend_scheduler #(.SLOTS(4), .MOTOR_TMO(255)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (vif)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Entered in IDLE with sel/credit already applied; returns in IDLE.
  task automatic purchase(input string tag, input logic [3:0] g, input logic [6:0] amt);
    tick;
    check({tag, "_grant"}, vif.grant, g);
    tick;
    check({tag, "_amt"}, vif.debit_amt, amt);
    vif.debit_ack = 1'b1;
    tick;
    vif.debit_ack = 1'b0;
    check({tag, "_motor"}, vif.motor_req, g);
    vif.motor_done = 1'b1;
    tick;
    vif.motor_done = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    vif.sel         = '0;
    vif.cancel      = 1'b0;
    vif.credit      = '0;
    vif.debit_ack   = 1'b0;
    vif.motor_done  = 1'b0;
    vif.eject_ready = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    #1;
    check("rst_busy", vif.busy, 0);
    check("rst_fault", vif.fault, 0);
    check("rst_grant", vif.grant, 0);
    check("rst_debit", vif.debit_valid, 0);
    check("rst_motor", vif.motor_req, 0);
    check("rst_coin", vif.coin_eject, 0);
    check("rst_rr", dut.rr_ptr, 0);

    // Single purchase, slot 0, with a one-cycle ack stall
    vif.credit = 7'd30;
    vif.sel    = 4'b0001;
    #1;
    check("t1_idle_grant", vif.grant, 0);
    tick;
    check("t1_grant", vif.grant, 4'b0001);
    check("t1_busy", vif.busy, 1);
    tick;
    vif.sel = '0;
    check("t1_dv", vif.debit_valid, 1);
    check("t1_amt", vif.debit_amt, 25);
    tick;
    check("t1_amt_hold", vif.debit_amt, 25);
    vif.debit_ack = 1'b1;
    tick;
    vif.debit_ack = 1'b0;
    check("t1_motor", vif.motor_req, 4'b0001);
    check("t1_dv_off", vif.debit_valid, 0);
    tick;
    vif.motor_done = 1'b1;
    tick;
    vif.motor_done = 1'b0;
    check("t1_idle", vif.busy, 0);
    check("t1_rr", dut.rr_ptr, 1);

    // Insufficient credit for slot 3
    vif.credit = 7'd20;
    vif.sel    = 4'b1000;
    tick;
    check("t2_reject", vif.reject, 4'b1000);
    check("t2_grant", vif.grant, 0);
    tick;
    vif.sel = '0;
    check("t2_idle", vif.busy, 0);
    check("t2_dv", vif.debit_valid, 0);
    check("t2_rr", dut.rr_ptr, 1);

    // Round-robin with sel held at 1011 starting from rr_ptr=1
    vif.credit = 7'd127;
    vif.sel    = 4'b1011;
    purchase("rr1", 4'b0010, 7'd30);
    purchase("rr2", 4'b1000, 7'd40);
    purchase("rr3", 4'b0001, 7'd25);
    vif.sel = '0;
    check("t3_rr", dut.rr_ptr, 1);

    // cancel with zero credit blocks sel and stays in IDLE
    vif.credit = '0;
    vif.cancel = 1'b1;
    vif.sel    = 4'b0001;
    tick;
    check("t4_cancel_zero", vif.busy, 0);
    vif.cancel = 1'b0;
    vif.sel    = '0;

    // Refund of 33 -> 20 + 10 + 2 + 1
    vif.credit      = 7'd33;
    vif.cancel      = 1'b1;
    vif.eject_ready = 1'b1;
    tick;
    vif.cancel = 1'b0;
    vif.credit = '0;
    check("t5_coin1", vif.coin_eject, 4'b1000);
    tick;
    check("t5_coin2", vif.coin_eject, 4'b0100);
    tick;
    check("t5_coin3", vif.coin_eject, 4'b0010);
    tick;
    check("t5_coin4", vif.coin_eject, 4'b0001);
    tick;
    check("t5_coin_done", vif.coin_eject, 0);
    tick;
    check("t5_dv", vif.debit_valid, 1);
    check("t5_amt", vif.debit_amt, 33);
    vif.debit_ack = 1'b1;
    tick;
    vif.debit_ack = 1'b0;
    check("t5_idle", vif.busy, 0);

    // Reset mid-refund with hopper stalled
    vif.credit      = 7'd12;
    vif.cancel      = 1'b1;
    vif.eject_ready = 1'b0;
    tick;
    vif.cancel = 1'b0;
    check("t6_stall_coin", vif.coin_eject, 0);
    check("t6_busy", vif.busy, 1);
    check("t6_rem", dut.rem, 12);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("t6_rst_busy", vif.busy, 0);
    check("t6_rst_dv", vif.debit_valid, 0);
    check("t6_rst_coin", vif.coin_eject, 0);
    check("t6_rst_rr", dut.rr_ptr, 0);
    tick;
    check("t6_no_debit", vif.debit_valid, 0);
    check("t6_still_idle", vif.busy, 0);

    // Exact-price grant; motor_done on the timeout cycle wins
    vif.credit = 7'd15;
    vif.sel    = 4'b0100;
    tick;
    check("t7_grant", vif.grant, 4'b0100);
    tick;
    vif.sel       = '0;
    vif.debit_ack = 1'b1;
    tick;
    vif.debit_ack = 1'b0;
    check("t7_motor", vif.motor_req, 4'b0100);
    repeat (255) tick;
    check("t7_motor_late", vif.motor_req, 4'b0100);
    vif.motor_done = 1'b1;
    tick;
    vif.motor_done = 1'b0;
    check("t7_idle", vif.busy, 0);
    check("t7_fault", vif.fault, 0);

    // Motor timeout -> sticky FAULT
    vif.credit = 7'd127;
    vif.sel    = 4'b0100;
    tick;
    check("t8_grant", vif.grant, 4'b0100);
    tick;
    vif.sel       = '0;
    vif.debit_ack = 1'b1;
    tick;
    vif.debit_ack = 1'b0;
    n = 0;
    while (!vif.fault && n < 400) begin
      tick;
      n++;
    end
    check("t8_tmo_cycles", n, 256);
    check("t8_fault", vif.fault, 1);
    check("t8_motor_off", vif.motor_req, 0);
    vif.sel         = 4'b0001;
    vif.cancel      = 1'b1;
    vif.credit      = 7'd50;
    vif.eject_ready = 1'b1;
    repeat (3) tick;
    check("t8_sticky", vif.fault, 1);
    check("t8_no_grant", vif.grant, 0);
    check("t8_no_coin", vif.coin_eject, 0);
    vif.sel         = '0;
    vif.cancel      = 1'b0;
    vif.eject_ready = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("t8_rst_fault", vif.fault, 0);
    check("t8_rst_busy", vif.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
